// File: rtl/williams2_pkg.sv
// Shared constants for the williams2 ROM loader:
// region map, region indices, download size and FSM states.
package williams2_pkg;

  localparam logic [18:0] PROG_LIM  = 19'h0FFFF;
  localparam logic [18:0] BANK_BASE = 19'h10000;
  localparam logic [18:0] BANK_LIM  = 19'h4FFFF;
  localparam logic [18:0] SND_BASE  = 19'h50000;
  localparam logic [18:0] SND_LIM   = 19'h5FFFF;
  localparam logic [18:0] GFX_BASE  = 19'h60000;
  localparam logic [18:0] GFX_LIM   = 19'h67FFF;

  localparam int RGN_PROG = 0;
  localparam int RGN_BANK = 1;
  localparam int RGN_SND  = 2;
  localparam int RGN_GFX  = 3;

  localparam logic [18:0] EXP_BYTES_DEF = 19'h68000;
  localparam logic [18:0] CNT_MAX       = 19'h7FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational address decode: download byte address to
// one-hot region hit plus offset within that region.
module rom_region_decode
  import williams2_pkg::*;
(
  input  logic [18:0] i_addr,
  output logic [3:0]  o_hit,
  output logic [17:0] o_offset,
  output logic        o_miss
);

  logic [18:0] w_base;

  always_comb begin
    o_hit  = '0;
    o_miss = 1'b0;
    w_base = '0;
    unique case (1'b1)
      (i_addr <= PROG_LIM): begin
        o_hit[RGN_PROG] = 1'b1;
      end
      (i_addr >= BANK_BASE && i_addr <= BANK_LIM): begin
        o_hit[RGN_BANK] = 1'b1;
        w_base          = BANK_BASE;
      end
      (i_addr >= SND_BASE && i_addr <= SND_LIM): begin
        o_hit[RGN_SND] = 1'b1;
        w_base         = SND_BASE;
      end
      (i_addr >= GFX_BASE && i_addr <= GFX_LIM): begin
        o_hit[RGN_GFX] = 1'b1;
        w_base         = GFX_BASE;
      end
      default: o_miss = 1'b1;
    endcase
    o_offset = 18'(i_addr - w_base);
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// HPS ROM download controller: routes bytes into region
// write enables and sequences the williams2 core reset.
module rom_load_ctrl
  import williams2_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter logic [18:0] EXPECTED_BYTES = EXP_BYTES_DEF
) (
  input  logic        clock_12,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_index,
  input  logic [18:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic [3:0]  rgn_we,
  output logic [17:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [18:0] byte_count
);

  localparam logic [31:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 32'd0 : 32'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_dl_q;
  logic        r_dl_vld;
  logic        r_oob;
  logic [31:0] r_settle;
  logic [18:0] r_count;
  logic [3:0]  r_we;
  logic [17:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_core_reset;
  logic        r_done;
  logic        r_err;

  logic        w_rise;
  logic        w_fall;
  logic        w_accept;
  logic        w_enter_load;
  logic        w_settle_done;
  logic [3:0]  w_hit;
  logic [17:0] w_off;
  logic        w_miss;

  rom_region_decode u_dec (
    .i_addr   (dn_addr),
    .o_hit    (w_hit),
    .o_offset (w_off),
    .o_miss   (w_miss)
  );

  // r_dl_vld masks the stale copy right after reset, so a
  // level still high across reset is not seen as an edge.
  assign w_rise = dn_download & ~r_dl_q & r_dl_vld;
  assign w_fall = ~dn_download & r_dl_q & r_dl_vld;

  assign w_accept = dn_wr && (dn_index == 16'd0)
                 && dn_download && (r_state == ST_LOAD);

  assign w_settle_done = (r_settle == SETTLE_LAST);
  assign w_enter_load  = (w_next == ST_LOAD)
                      && (r_state != ST_LOAD);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_rise) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_fall) begin
          if (r_count == EXPECTED_BYTES && !r_oob)
            w_next = ST_SETTLE;
          else
            w_next = ST_ERROR;
        end
      end
      ST_SETTLE: begin
        if (w_rise)             w_next = ST_LOAD;
        else if (w_settle_done) w_next = ST_RUN;
      end
      ST_RUN:   if (w_rise) w_next = ST_LOAD;
      ST_ERROR: if (w_rise) w_next = ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_dl_q       <= 1'b0;
      r_dl_vld     <= 1'b0;
      r_settle     <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_dl_q       <= dn_download;
      r_dl_vld     <= 1'b1;
      r_core_reset <= (w_next != ST_RUN);
      r_done       <= (w_next == ST_RUN);
      r_err        <= (w_next == ST_ERROR);
      if (r_state == ST_SETTLE && w_next == ST_SETTLE)
        r_settle <= r_settle + 32'd1;
      else
        r_settle <= '0;
    end
  end

  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_oob     <= 1'b0;
      r_we      <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_we <= (w_accept && !w_miss) ? w_hit : 4'd0;
      if (w_accept) begin
        r_wr_addr <= w_off;
        r_wr_data <= dn_data;
      end
      if (w_enter_load) begin
        r_count <= '0;
        r_oob   <= 1'b0;
      end else if (w_accept) begin
        if (r_count != CNT_MAX) r_count <= r_count + 19'd1;
        if (w_miss) r_oob <= 1'b1;
      end
    end
  end

  assign rgn_we     = r_we;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign core_reset = r_core_reset;
  assign load_done  = r_done;
  assign load_err   = r_err;
  assign byte_count = r_count;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Randomized bench for rom_load_ctrl with a behavioural
// reference model and a per-cycle compare process.
module tb_rom_load_ctrl;

  localparam int          SC = 16;
  localparam logic [18:0] EB = 19'd200;

  localparam int M_IDLE   = 0;
  localparam int M_LOAD   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_ERR    = 4;

  logic        clock_12;
  logic        reset_n;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_index;
  logic [18:0] dn_addr;
  logic [7:0]  dn_data;
  logic [3:0]  rgn_we;
  logic [17:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [18:0] byte_count;

  rom_load_ctrl #(
    .SETTLE_CYCLES  (SC),
    .EXPECTED_BYTES (EB)
  ) dut (
    .clock_12    (clock_12),
    .reset_n     (reset_n),
    .dn_download (dn_download),
    .dn_wr       (dn_wr),
    .dn_index    (dn_index),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .rgn_we      (rgn_we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .core_reset  (core_reset),
    .load_done   (load_done),
    .load_err    (load_err),
    .byte_count  (byte_count)
  );

  initial clock_12 = 1'b0;
  always #5 clock_12 = ~clock_12;

  int total;
  int bad;
  bit chk_en;

  int rb[4] = '{32'h00000, 32'h10000, 32'h50000, 32'h60000};
  int rs[4] = '{32'h10000, 32'h40000, 32'h10000, 32'h08000};
  int dut_tally[4];
  int exp_tally[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int region_of(input logic [18:0] a);
    for (int i = 0; i < 4; i++)
      if (int'(a) >= rb[i] && int'(a) < rb[i] + rs[i])
        return i;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  int          m_mode;
  bit          m_prev_dl;
  bit          m_prev_ok;
  int          m_cnt;
  bit          m_oob;
  int          m_left;
  bit          m_rise;
  bit          m_fall;
  bit          m_acc;
  int          m_r;
  logic [3:0]  e_we;
  logic [17:0] e_addr;
  logic [7:0]  e_data;

  always @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      m_mode    = M_IDLE;
      m_prev_dl = 1'b0;
      m_prev_ok = 1'b0;
      m_cnt     = 0;
      m_oob     = 1'b0;
      m_left    = 0;
      e_we      = '0;
      e_addr    = '0;
      e_data    = '0;
    end else begin
      m_rise = dn_download && m_prev_ok && !m_prev_dl;
      m_fall = !dn_download && m_prev_ok && m_prev_dl;
      m_acc  = dn_wr && dn_index == 16'd0 && dn_download
            && m_mode == M_LOAD;
      e_we = '0;
      if (m_acc) begin
        m_r = region_of(dn_addr);
        if (m_r < 0) m_oob = 1'b1;
        else begin
          e_we   = 4'(1 << m_r);
          e_addr = 18'(int'(dn_addr) - rb[m_r]);
          e_data = dn_data;
        end
        if (m_cnt < 32'h7FFFF) m_cnt++;
      end
      case (m_mode)
        M_LOAD: begin
          if (m_fall) begin
            if (m_cnt == int'(EB) && !m_oob) begin
              m_mode = M_SETTLE;
              m_left = (SC > 0) ? SC : 1;
            end else m_mode = M_ERR;
          end
        end
        M_SETTLE: begin
          if (m_rise) begin
            m_mode = M_LOAD; m_cnt = 0; m_oob = 1'b0;
          end else begin
            m_left--;
            if (m_left == 0) m_mode = M_RUN;
          end
        end
        default: begin
          if (m_rise) begin
            m_mode = M_LOAD; m_cnt = 0; m_oob = 1'b0;
          end
        end
      endcase
      m_prev_dl = dn_download;
      m_prev_ok = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock_12) begin
    if (chk_en) begin
      chk("rgn_we", 32'(rgn_we), 32'(e_we));
      chk("core_reset", 32'(core_reset),
          32'(m_mode != M_RUN));
      chk("load_done", 32'(load_done), 32'(m_mode == M_RUN));
      chk("load_err", 32'(load_err), 32'(m_mode == M_ERR));
      chk("byte_count", 32'(byte_count), m_cnt);
      if (e_we != 4'd0) begin
        chk("wr_addr", 32'(wr_addr), 32'(e_addr));
        chk("wr_data", 32'(wr_data), 32'(e_data));
      end
      for (int i = 0; i < 4; i++)
        if (rgn_we[i]) dut_tally[i]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit dl, input bit wr,
                     input logic [15:0] idx,
                     input logic [18:0] a,
                     input logic [7:0] d);
    @(posedge clock_12);
    #2;
    dn_download = dl;
    dn_wr       = wr;
    dn_index    = idx;
    dn_addr     = a;
    dn_data     = d;
  endtask

  task automatic start_load();
    for (int i = 0; i < 4; i++) begin
      dut_tally[i] = 0;
      exp_tally[i] = 0;
    end
    cyc(1'b1, 1'b1, 16'd0, 19'd0, 8'hAA);
  endtask

  task automatic send_bytes(input int n, input bit put_oob);
    logic [18:0] a;
    int r;
    bit prev_oob;
    a = '0; r = 0; prev_oob = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0)
        cyc(1'b1, 1'b1, 16'($urandom_range(1, 65535)),
            19'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0)
        cyc(1'b1, 1'b0, 16'd0, 19'd0, 8'd0);
      if (put_oob && i == n / 2) begin
        a = 19'h70000;
        prev_oob = 1'b1;
      end else if (prev_oob || $urandom_range(0, 7) != 0) begin
        r = $urandom_range(0, 3);
        a = 19'(rb[r] + $urandom_range(0, rs[r] - 1));
        exp_tally[r]++;
        prev_oob = 1'b0;
      end else begin
        exp_tally[r]++;
      end
      cyc(1'b1, 1'b1, 16'd0, a, 8'($urandom));
    end
  endtask

  task automatic end_load(input bit wr_on_fall);
    cyc(1'b0, wr_on_fall, 16'd0, 19'h00123, 8'h5A);
  endtask

  task automatic wait_run(input string nm, output int k);
    k = 0;
    while (!load_done && k < 200) begin
      @(negedge clock_12);
      k++;
    end
    chk(nm, 32'(load_done), 32'd1);
  endtask

  task automatic check_tally(input string nm);
    for (int i = 0; i < 4; i++)
      chk(nm, 32'(dut_tally[i]), 32'(exp_tally[i]));
  endtask

  task automatic idle_and_check_err(input logic [18:0] cnt);
    @(posedge clock_12);
    @(negedge clock_12);
    chk("err_flag", 32'(load_err), 32'd1);
    chk("err_core_reset", 32'(core_reset), 32'd1);
    chk("err_count", 32'(byte_count), 32'(cnt));
    repeat (3) cyc(1'b0, 1'b0, 16'd0, 19'd0, 8'd0);
  endtask

  logic [18:0] b_addr[10] = '{
    19'h00000, 19'h0FFFF, 19'h10000, 19'h4FFFF, 19'h50000,
    19'h5FFFF, 19'h60000, 19'h67FFF, 19'h68000, 19'h7FFFF
  };
  logic [3:0]  b_we[10] = '{
    4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
    4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000
  };
  logic [17:0] b_off[10] = '{
    18'h00000, 18'h0FFFF, 18'h00000, 18'h3FFFF, 18'h00000,
    18'h0FFFF, 18'h00000, 18'h07FFF, 18'h00000, 18'h00000
  };

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    total = 0; bad = 0; chk_en = 1'b0;
    reset_n = 1'b1;
    dn_download = 1'b0; dn_wr = 1'b0; dn_index = '0;
    dn_addr = '0; dn_data = '0;
    #3 reset_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_rgn_we", 32'(rgn_we), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    repeat (3) @(posedge clock_12);
    #2 reset_n = 1'b1;

    // strobes while no download is active
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 16'd0, 19'($urandom_range(0, 32'h67FFF)),
          8'($urandom));
    cyc(1'b0, 1'b0, 16'd0, 19'd0, 8'd0);
    @(negedge clock_12);
    chk("nodl_count", 32'(byte_count), 32'd0);

    // boundary addresses, then a short load into ERROR
    start_load();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 16'd0, b_addr[i], 8'(i + 16));
      cyc(1'b1, 1'b0, 16'd0, 19'd0, 8'd0);
      @(negedge clock_12);
      chk("bnd_we", 32'(rgn_we), 32'(b_we[i]));
      if (b_we[i] != 4'd0)
        chk("bnd_off", 32'(wr_addr), 32'(b_off[i]));
    end
    cyc(1'b1, 1'b1, 16'd1, 19'h00100, 8'h77);
    cyc(1'b1, 1'b0, 16'd0, 19'd0, 8'd0);
    @(negedge clock_12);
    chk("idx1_we", 32'(rgn_we), 32'd0);
    chk("idx1_count", 32'(byte_count), 32'd10);
    end_load(1'b0);
    idle_and_check_err(19'd10);

    // good load, fall coincides with a strobe
    start_load();
    send_bytes(int'(EB), 1'b0);
    end_load(1'b1);
    wait_run("good_run", k);
    chk("settle_len", 32'(k), 32'(SC + 2));
    chk("good_count", 32'(byte_count), 32'(EB));
    chk("good_core_reset", 32'(core_reset), 32'd0);
    check_tally("good_tally");
    repeat (3) cyc(1'b0, 1'b0, 16'd0, 19'd0, 8'd0);

    // reload from RUN
    cyc(1'b1, 1'b0, 16'd0, 19'd0, 8'd0);
    @(posedge clock_12);
    @(negedge clock_12);
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    chk("reload_count", 32'(byte_count), 32'd0);
    chk("reload_done", 32'(load_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      dut_tally[i] = 0;
      exp_tally[i] = 0;
    end
    send_bytes(int'(EB), 1'b0);
    end_load(1'b0);
    wait_run("reload_run", k);
    check_tally("reload_tally");
    repeat (3) cyc(1'b0, 1'b0, 16'd0, 19'd0, 8'd0);

    // short by one byte
    start_load();
    send_bytes(int'(EB) - 1, 1'b0);
    end_load(1'b0);
    idle_and_check_err(EB - 19'd1);

    // right count but one byte outside the map
    start_load();
    send_bytes(int'(EB), 1'b1);
    end_load(1'b0);
    idle_and_check_err(EB);
    check_tally("oob_tally");

    // reset in the middle of a download
    start_load();
    send_bytes(50, 1'b0);
    @(posedge clock_12);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(rgn_we), 32'd0);
    chk("mid_rst_core", 32'(core_reset), 32'd1);
    chk("mid_rst_count", 32'(byte_count), 32'd0);
    chk("mid_rst_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_data", 32'(wr_data), 32'd0);
    chk("mid_rst_flags", 32'({load_done, load_err}), 32'd0);
    repeat (2) @(posedge clock_12);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, 16'd0, 19'(i), 8'(i));
    @(negedge clock_12);
    chk("post_rst_count", 32'(byte_count), 32'd0);
    chk("post_rst_we", 32'(rgn_we), 32'd0);
    cyc(1'b0, 1'b0, 16'd0, 19'd0, 8'd0);
    start_load();
    send_bytes(int'(EB), 1'b0);
    end_load(1'b0);
    wait_run("post_rst_run", k);
    check_tally("post_rst_tally");
    repeat (3) cyc(1'b0, 1'b0, 16'd0, 19'd0, 8'd0);

    @(negedge clock_12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 256: clock_12 cycles that core_reset stays asserted after a good download.
REQ-002 Parameter EXPECTED_BYTES, default 19'h68000: exact byte count for a good download.
REQ-003 clock_12  in  1  sole clock; every register is on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dn_download  in  1  download-in-progress level from the HPS side.
REQ-006 dn_wr  in  1  single-cycle byte strobe.
REQ-007 dn_index  in  16  download index; only index 0 is accepted.
REQ-008 dn_addr  in  19  byte address within the download.
REQ-009 dn_data  in  8  byte value.
REQ-010 rgn_we  out  4  one-hot region write enables (0 prog, 1 bank, 2 sound, 3 gfx).
REQ-011 wr_addr  out  18  byte offset within the selected region.
REQ-012 wr_data  out  8  registered copy of dn_data.
REQ-013 core_reset  out  1  active-high reset to the williams2 core.
REQ-014 load_done  out  1  high only in state RUN.
REQ-015 load_err  out  1  high only in state ERROR.
REQ-016 byte_count  out  19  count of accepted bytes in the current or last download.

Function
REQ-017 Region map, inclusive: prog 0x00000-0x0FFFF; bank 0x10000-0x4FFFF; sound 0x50000-0x5FFFF; gfx 0x60000-0x67FFF.
REQ-018 A byte is accepted only when dn_wr=1, dn_index=0, dn_download=1 and the state is LOAD.
REQ-019 An accepted in-map byte drives exactly one rgn_we bit for one cycle, exactly 1 cycle after the dn_wr cycle.
  - wr_addr = dn_addr minus the region base, zero-extended to 18 bits.
  - wr_data = dn_data.
REQ-020 rgn_we is 0 in every cycle not covered by REQ-019.
REQ-021 Accepted-byte rules:
  - every accepted byte increments byte_count, saturating at 19'h7FFFF;
  - a repeated address counts again;
  - an accepted byte at an address above 0x67FFF produces no rgn_we and sets the internal sticky flag oob.
REQ-022 FSM states are IDLE, LOAD, SETTLE, RUN and ERROR.
REQ-023 IDLE: core_reset=1; a rising edge of dn_download moves to LOAD.
REQ-024 LOAD: core_reset=1.
  - Entry clears byte_count and oob in the same cycle.
  - Falling edge of dn_download with byte_count==EXPECTED_BYTES and oob=0 moves to SETTLE.
  - Falling edge of dn_download in any other case moves to ERROR.
REQ-025 SETTLE: core_reset=1; a counter runs from 0.
  - The FSM moves to RUN in the cycle after the counter reaches SETTLE_CYCLES-1.
  - With SETTLE_CYCLES=0 the FSM moves to RUN 1 cycle after entering SETTLE.
REQ-026 RUN: core_reset=0.
REQ-027 ERROR: core_reset=1 and is held there.
REQ-028 A rising edge of dn_download in SETTLE, RUN or ERROR moves to LOAD, with the clears of REQ-024.
REQ-029 If dn_wr coincides with the falling edge of dn_download, that byte is not accepted and is not counted.
REQ-030 Edge detection uses a 1-cycle registered copy of dn_download.
  - The rising-edge transition into LOAD takes effect on the edge after dn_download rises.
  - A byte strobed in that first cycle is dropped.
REQ-031 State-to-output latency:
  - core_reset, load_done and load_err are registered outputs.
  - Each follows a state change with 0 extra cycles; it is decoded from the state register.

Reset
REQ-032 While reset_n=0, the block is immediately in the reset condition:
  - state is IDLE;
  - core_reset=1, rgn_we=0, wr_addr=0, wr_data=0;
  - load_done=0, load_err=0, byte_count=0;
  - oob=0, the settle counter is 0, and the registered dn_download copy is 0.
REQ-033 Reset asserted mid-LOAD abandons the download.
  - After release the block is in IDLE.
  - If dn_download is still high after release, no LOAD is entered until the next rising edge of dn_download.

Structure
REQ-034 The region bases and limits, region index constants, EXPECTED_BYTES default and the state enum live in the shared package williams2_pkg.
REQ-035 The region decode is one combinational sub-module, rom_region_decode.
  - Input: a 19-bit address.
  - Outputs: a 4-bit one-hot hit, an 18-bit offset, and a miss flag.
REQ-036 The FSM, counters and output registers live in rom_load_ctrl itself.

Verification
REQ-037 Good load: write 0x68000 sequential bytes at index 0, then drop dn_download.
  - Required: rgn_we pulses distribute 0x10000/0x40000/0x10000/0x8000 per region.
  - Required: SETTLE lasts 256 cycles, then load_done=1 and core_reset=0.
REQ-038 Short load: drop dn_download after 0x67FFF bytes -> load_err=1, core_reset stays 1, byte_count=0x67FFF.
REQ-039 Out-of-map write: send 0x68000 bytes where one is at address 0x70000 (others in map), then drop dn_download.
  - Required: no rgn_we for the 0x70000 byte, and the block ends in ERROR.
REQ-040 Filtering:
  - dn_wr with dn_index=1 -> no rgn_we and byte_count unchanged;
  - dn_wr while dn_download=0 -> ignored.
REQ-041 Reset mid-load: pulse reset_n low at byte 0x1234.
  - Required: all outputs go to reset values immediately; IDLE after release; no LOAD until a new rising edge of dn_download.
REQ-042 Reload from RUN: raise dn_download in RUN.
  - Required: next cycle core_reset=1, byte_count=0, load_done=0.
  - Required: a second good load returns to RUN.
